// File: rtl/fp32_recip_pack.sv
// fp32_recip_pack: pack an IEEE-754 single reciprocal 1/x from the operand and
// the normalized reciprocal mantissa supplied by the Newton core.
// Two-stage elastic pipeline: S1 classifies the operand, S2 packs the result and flags.
module fp32_recip_pack #(
  parameter int FLT_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [31:0]          i_x,
  input  logic [FLT_WIDTH-1:0] i_recip_man,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [31:0]          o_result,
  output logic [3:0]           o_flags,
  output logic [CNT_WIDTH-1:0] o_dbz_cnt
);

  // Operand class, decided once at S1 capture.
  typedef enum logic [1:0] {CL_NORM, CL_DBZ, CL_INF, CL_NAN} cls_t;

  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
  localparam int                   XW      = EXP_WIDTH + 2;
  // 2*bias = 254; result exponent for an exact power of two is 254-e.
  localparam logic [XW-1:0]        EXP_TOP = {2'b00, EXP_MAX - EXP_WIDTH'(1)};

  // vld_pipe[1] = S1 occupied, vld_pipe[2] = S2 occupied
  logic [2:1]           vld_pipe;
  logic                 s1_adv, s2_adv, accept;

  logic                 in_sign;
  logic [EXP_WIDTH-1:0] in_exp;
  logic                 in_fz;
  cls_t                 in_cls;

  logic                 s1_sign;
  logic [EXP_WIDTH-1:0] s1_exp;
  logic                 s1_fz;
  logic [FLT_WIDTH-1:0] s1_rman;
  cls_t                 s1_cls;

  logic [XW-1:0]        exp_calc;
  logic                 uflow;
  logic [31:0]          nxt_res;
  logic [3:0]           nxt_flags;

  assign in_sign = i_x[31];
  assign in_exp  = i_x[FLT_WIDTH +: EXP_WIDTH];
  assign in_fz   = (i_x[FLT_WIDTH-1:0] == '0);

  // S2 drains when empty or being consumed; S1 moves when S2 can take it.
  assign s2_adv  = !vld_pipe[2] || i_ready;
  assign s1_adv  = !vld_pipe[1] || s2_adv;
  assign o_ready = s1_adv;
  assign accept  = i_valid && o_ready;
  assign o_valid = vld_pipe[2];

  // Classify the incoming operand; denormals (e==0) count as zero.
  always_comb begin
    in_cls = CL_NORM;
    if (in_exp == '0)          in_cls = CL_DBZ;
    else if (in_exp == EXP_MAX) in_cls = in_fz ? CL_INF : CL_NAN;
  end

  // Valid bits for both stages; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= i_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // S1 operand capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_fz   <= 1'b0;
      s1_rman <= '0;
      s1_cls  <= CL_NORM;
    end else if (accept) begin
      s1_sign <= in_sign;
      s1_exp  <= in_exp;
      s1_fz   <= in_fz;
      s1_rman <= i_recip_man;
      s1_cls  <= in_cls;
    end
  end

  // A non-power-of-two mantissa gives 2/(1.f) in [1,2) scaled by 1/2, so one
  // less exponent. Exponent math is 10-bit; a zero or negative result underflows.
  assign exp_calc = EXP_TOP - {2'b00, s1_exp} - {{(XW-1){1'b0}}, !s1_fz};
  assign uflow    = exp_calc[XW-1] || (exp_calc == '0);

  // Pack result and flags {nan, div_by_zero, underflow, exact}.
  always_comb begin
    nxt_res   = '0;
    nxt_flags = '0;
    case (s1_cls)
      CL_NAN: begin
        nxt_res   = 32'h7FC0_0000;
        nxt_flags = 4'b1000;
      end
      CL_DBZ: begin
        nxt_res   = {s1_sign, EXP_MAX, {FLT_WIDTH{1'b0}}};
        nxt_flags = 4'b0100;
      end
      CL_INF: begin
        nxt_res   = {s1_sign, 31'b0};
      end
      default: begin
        if (uflow) begin
          nxt_res   = {s1_sign, 31'b0};
          nxt_flags = 4'b0010;
        end else begin
          nxt_res   = {s1_sign, exp_calc[EXP_WIDTH-1:0],
                       s1_fz ? {FLT_WIDTH{1'b0}} : s1_rman};
          nxt_flags = {3'b000, s1_fz};
        end
      end
    endcase
  end

  // S2 result register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_result <= '0;
      o_flags  <= '0;
    end else if (s2_adv && vld_pipe[1]) begin
      o_result <= nxt_res;
      o_flags  <= nxt_flags;
    end
  end

  // Saturating count of accepted divide-by-zero operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_dbz_cnt <= '0;
    end else if (accept && in_cls == CL_DBZ && o_dbz_cnt != '1) begin
      o_dbz_cnt <= o_dbz_cnt + 1'b1;
    end
  end

endmodule

// File: doc/fp32_recip_pack.md
FP32_RECIP_PACK -- requirements
Module: fp32_recip_pack

Interface
REQ-001 Parameter FLT_WIDTH, default 23, mantissa fraction width; only 23 is supported.
REQ-002 Parameter EXP_WIDTH, default 8, exponent field width; only 8 is supported.
REQ-003 Parameter CNT_WIDTH, default 16, width of the divide-by-zero event counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 i_valid  input  1  upstream presents an operand this cycle.
REQ-007 o_ready  output  1  block accepts the operand; a transfer occurs when i_valid && o_ready.
REQ-008 i_x  input  32  original IEEE-754 single operand: sign, exponent, fraction.
REQ-009 i_recip_man  input  23  fraction of the normalized reciprocal mantissa 2/(1.f) from the Newton reciprocal core; 0 when f==0; valid in the same cycle as i_x.
REQ-010 o_valid  output  1  result is held on o_result/o_flags.
REQ-011 i_ready  input  1  downstream consumes; a transfer occurs when o_valid && i_ready.
REQ-012 o_result  output  32  IEEE-754 single result 1/x.
REQ-013 o_flags  output  4  {nan, div_by_zero, underflow, exact}, aligned with o_result.
REQ-014 o_dbz_cnt  output  CNT_WIDTH  saturating count of accepted divide-by-zero operands.

Function
REQ-015 Block is a 2-stage pipeline: S1 registers sign, exponent e, fraction-zero flag, i_recip_man, and the special-case class; S2 registers the packed result and flags.
REQ-016 Latency is exactly 2 cycles from the accepting edge to o_valid, with no backpressure.
REQ-017 Throughput is one operand per cycle when i_ready is held high.
REQ-018 o_ready = !s1_valid || !s2_valid || i_ready; a stage advances only when the stage downstream of it is empty or draining.
REQ-019 Data presented with o_valid is held stable until it is consumed; no result is dropped, duplicated or reordered.
REQ-020 Normal case (1 <= e <= 254): sign is copied; if f==0, exp_out = 254-e and man_out = 0, and exact=1; if f!=0, exp_out = 253-e and man_out = i_recip_man.
REQ-021 Exponent arithmetic uses 10-bit signed width; a result of exp_out <= 0 flushes to signed zero with underflow=1 (for example e=254 with f!=0, or e=254 with f==0).
REQ-022 e==0 (zero or denormal; denormals flush to zero) gives signed infinity {s,0xFF,0} with div_by_zero=1.
REQ-023 e==255 with f==0 gives signed zero with no flags set.
REQ-024 e==255 with f!=0 gives canonical NaN 0x7FC00000 with nan=1; sign is ignored.
REQ-025 At most one of nan, div_by_zero or underflow is set per result.
REQ-026 o_dbz_cnt increments by one on each accepted operand classed as div_by_zero, counted at S1 capture, and saturates at all-ones.

Reset
REQ-027 While rst_n==0 at a clock edge: s1_valid=0, s2_valid=0, o_valid=0, o_result=0, o_flags=0, o_dbz_cnt=0.
REQ-028 o_ready evaluates to 1 during and immediately after reset.
REQ-029 Reset asserted mid-operation discards all in-flight operands; no result for them ever appears.

Verification
REQ-030 i_x=0x40000000, recip_man=0 -> o_result=0x3F000000, flags=0001, o_valid exactly 2 cycles after acceptance.
REQ-031 i_x=0x3FC00000, recip_man=0x2AAAAB -> 0x3F2AAAAB, flags=0000; i_x=0xBFC00000 -> 0xBF2AAAAB.
REQ-032 Special cases:
- i_x=0x00000000 -> 0x7F800000, flags=0100, o_dbz_cnt 0->1.
- i_x=0x80000001 -> 0xFF800000.
- i_x=0xFF800000 -> 0x80000000.
- i_x=0x7FC12345 -> 0x7FC00000, flags=1000.
REQ-033 i_x=0x7F000001, recip_man=0x7FFFFE -> 0x00000000, flags=0010; i_x=0x7F000000 -> 0x00000000, flags=0010.
REQ-034 Stream 5 operands back-to-back with i_ready low for cycles 2-5:
- o_ready drops once both stages are full.
- All 5 results emerge in order, each held stable while stalled.
REQ-035 Assert rst_n=0 for 1 cycle while 2 operands are in flight -> no o_valid for them; o_dbz_cnt=0; the next operand returns after 2 cycles.
